pll_reset_seq: RTL and testbench

PLL_RESET_SEQ -- requirements
Module: pll_reset_seq

---
 rtl/pll_reset_pkg.sv | 15 +
 rtl/sync_ff2.sv | 25 ++
 rtl/pll_reset_seq.sv | 108 ++++++++++
 tb/tb_pll_reset_seq.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/pll_reset_pkg.sv
// Shared types and widths for the PLL reset sequencer and its helpers.
// Holds the sequencer state encoding, the shared counter width and the loss-count width.
package pll_reset_pkg;

  localparam int CNT_W  = 16;
  localparam int LOSS_W = 8;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABILIZE = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_e;

endpackage

// File: rtl/sync_ff2.sv
// Two-flop synchroniser for a single asynchronous input.
// Both flops clear to 0 on the synchronous reset.
module sync_ff2 (
  input  logic clock,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_seq.sv
// Holds downstream logic in reset until the PLL lock has been stable for a
// programmable time, then releases it; any captured lock drop restarts the sequence.
module pll_reset_seq
  import pll_reset_pkg::*;
#(
  parameter int LOCK_STABLE_CYCLES = 4800,
  parameter int RESET_HOLD_CYCLES  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pll_locked,
  output logic              sys_reset,
  output logic              ready,
  output logic              lock_loss,
  output logic [LOSS_W-1:0] lock_loss_count,
  output state_e            dbg_state
);

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RESET_HOLD_CYCLES - 1);

  logic              locked_s;
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              loss_d;
  logic              lock_loss_q;
  logic [LOSS_W-1:0] loss_cnt_q, loss_cnt_d;
  logic              sys_reset_q;
  logic              ready_q;

  sync_ff2 u_lock_sync (
    .clock (clock),
    .reset (reset),
    .d_i   (pll_locked),
    .q_o   (locked_s)
  );

  // A low locked_s always wins over the counter reaching its terminal value.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    loss_d  = 1'b0;
    case (state_q)
      WAIT_LOCK: begin
        cnt_d = '0;
        if (locked_s) state_d = STABILIZE;
      end
      STABILIZE: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HOLD: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RUN: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          loss_d  = 1'b1;
        end
      end
      default: state_d = WAIT_LOCK;
    endcase
  end

  always_comb begin
    loss_cnt_d = loss_cnt_q;
    if (loss_d && (loss_cnt_q != {LOSS_W{1'b1}})) loss_cnt_d = loss_cnt_q + LOSS_W'(1);
  end

  // Outputs are registered from state_q, giving one extra cycle of latency
  // after the synchroniser and the state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= WAIT_LOCK;
      cnt_q       <= '0;
      lock_loss_q <= 1'b0;
      loss_cnt_q  <= '0;
      sys_reset_q <= 1'b1;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lock_loss_q <= loss_d;
      loss_cnt_q  <= loss_cnt_d;
      sys_reset_q <= (state_q != RUN);
      ready_q     <= (state_q == RUN);
    end
  end

  assign sys_reset       = sys_reset_q;
  assign ready           = ready_q;
  assign lock_loss       = lock_loss_q;
  assign lock_loss_count = loss_cnt_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Directed bench for pll_reset_seq with LOCK_STABLE_CYCLES=8, RESET_HOLD_CYCLES=4.
// A vector table covers lock-up, lock loss and a stabilise-phase glitch; hand sequences cover the rest.
module tb_pll_reset_seq;
  import pll_reset_pkg::*;

  logic       clock;
  logic       reset;
  logic       pll_locked;
  logic       sys_reset;
  logic       ready;
  logic       lock_loss;
  logic [7:0] lock_loss_count;
  state_e     dbg_state;

  int n_vec;
  int n_miss;

  pll_reset_seq #(
    .LOCK_STABLE_CYCLES (8),
    .RESET_HOLD_CYCLES  (4)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .pll_locked      (pll_locked),
    .sys_reset       (sys_reset),
    .ready           (ready),
    .lock_loss       (lock_loss),
    .lock_loss_count (lock_loss_count),
    .dbg_state       (dbg_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // exp = {sys_reset, ready, lock_loss, lock_loss_count}
  typedef struct packed {
    logic        locked;
    logic        rst;
    logic [10:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic push_n(input int n, input logic l, input logic r, input logic sr,
                        input logic rdy, input logic ll, input logic [7:0] c);
    repeat (n) vecs.push_back('{locked: l, rst: r, exp: {sr, rdy, ll, c}});
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_ready(output bit reached, output int pulses);
    reached = 1'b0;
    pulses  = 0;
    for (int k = 0; k < 40 && !reached; k++) begin
      tick();
      if (lock_loss) pulses++;
      if (ready) reached = 1'b1;
    end
  endtask

  // From RUN: drop lock for 5 cycles, relock and wait for ready.
  task automatic lock_cycle(output int pulses, output bit reached);
    int p2;
    pulses     = 0;
    pll_locked = 1'b0;
    repeat (5) begin
      tick();
      if (lock_loss) pulses++;
    end
    pll_locked = 1'b1;
    wait_ready(reached, p2);
    pulses += p2;
  endtask

  initial begin
    int  pulses;
    bit  reached;
    bit  bad;
    n_vec      = 0;
    n_miss     = 0;
    reset      = 1'b1;
    pll_locked = 1'b0;

    // Lock-up from reset: sys_reset falls 15 cycles after first high sample.
    push_n(2,  0, 1, 1, 0, 0, 8'd0);
    push_n(15, 1, 0, 1, 0, 0, 8'd0);
    push_n(2,  1, 0, 0, 1, 0, 8'd0);
    // Lock drop in RUN for 5 cycles, then relock.
    push_n(2,  0, 0, 0, 1, 0, 8'd0);
    push_n(1,  0, 0, 0, 1, 1, 8'd1);
    push_n(2,  0, 0, 1, 0, 0, 8'd1);
    push_n(15, 1, 0, 1, 0, 0, 8'd1);
    push_n(2,  1, 0, 0, 1, 0, 8'd1);
    // Reset in RUN (no lock_loss), then a 2-cycle glitch at stabilise count 5.
    push_n(1,  1, 1, 1, 0, 0, 8'd0);
    push_n(6,  1, 0, 1, 0, 0, 8'd0);
    push_n(2,  0, 0, 1, 0, 0, 8'd0);
    push_n(15, 1, 0, 1, 0, 0, 8'd0);
    push_n(2,  1, 0, 0, 1, 0, 8'd0);

    foreach (vecs[i]) begin
      pll_locked = vecs[i].locked;
      reset      = vecs[i].rst;
      tick();
      check($sformatf("vec%0d", i), 32'({sys_reset, ready, lock_loss, lock_loss_count}),
            32'(vecs[i].exp));
    end

    // Saturation: 300 lock-loss events from RUN.
    for (int i = 0; i < 300; i++) begin
      lock_cycle(pulses, reached);
      check($sformatf("sat_pulses%0d", i), 32'(pulses), 32'd1);
      check($sformatf("sat_ready%0d", i), 32'(reached), 32'd1);
      check($sformatf("sat_count%0d", i), 32'(lock_loss_count), (i + 1 > 255) ? 32'd255 : 32'(i + 1));
      if (!reached) break;
    end

    // Reset in RUN with count=3.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_a_state", 32'(dbg_state), 32'(WAIT_LOCK));
    wait_ready(reached, pulses);
    check("rst_a_ready", 32'(reached), 32'd1);
    for (int i = 0; i < 3; i++) begin
      lock_cycle(pulses, reached);
      check($sformatf("c3_ready%0d", i), 32'(reached), 32'd1);
    end
    check("c3_count", 32'(lock_loss_count), 32'd3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_b_out", 32'({sys_reset, ready, lock_loss, lock_loss_count}), 32'({1'b1, 1'b0, 1'b0, 8'd0}));
    check("rst_b_state", 32'(dbg_state), 32'(WAIT_LOCK));
    bad = 1'b0;
    repeat (5) begin
      tick();
      if (lock_loss) bad = 1'b1;
    end
    check("rst_b_noloss", 32'(bad), 32'd0);

    // Lock toggling every cycle never releases reset.
    bad = 1'b0;
    pll_locked = 1'b0;
    repeat (100) begin
      tick();
      if (!sys_reset || ready || lock_loss) bad = 1'b1;
      pll_locked = ~pll_locked;
    end
    check("toggle_held", 32'(bad), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
